// File: rtl/ucsbece154b_mem_pkg.sv
// Shared types and constants for the memory arbiter and the caches that sit on it.
package ucsbece154b_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam int unsigned BLOCK_WORDS_DEFAULT = 4;
  localparam int unsigned WORD_SIZE_DEFAULT   = 32;
  localparam logic [31:0] NOP                 = 32'h00000013;

endpackage

// File: rtl/ucsbece154b_mem_arbiter.sv
// Round-robin arbiter granting the icache or dcache access to the SDRAM controller
// for one burst at a time; burst data is forwarded combinationally to the owner.
module ucsbece154b_mem_arbiter
  import ucsbece154b_mem_pkg::*;
#(
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEFAULT,
  parameter int unsigned WORD_SIZE   = WORD_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iReadRequest,
  input  logic [31:0]          iReadAddress,
  output logic [WORD_SIZE-1:0] iDataIn,
  output logic                 iDataReady,
  input  logic                 dReadRequest,
  input  logic [31:0]          dReadAddress,
  output logic [WORD_SIZE-1:0] dDataIn,
  output logic                 dDataReady,
  output logic                 memReadRequest,
  output logic [31:0]          memReadAddress,
  input  logic [WORD_SIZE-1:0] memDataIn,
  input  logic                 memDataReady,
  output logic                 grantD,
  output logic                 errBurst
);

  localparam int unsigned CW = $clog2(BLOCK_WORDS) + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);

  state_t        state;
  logic          last_grant;
  logic [CW-1:0] count;
  logic          pick_d;
  logic          owner_req;
  logic          owner_active;

  // dcache wins when it is the only requester, or on a tie when the icache went last
  assign pick_d       = dReadRequest & (~iReadRequest | ~last_grant);
  assign owner_req    = grantD ? dReadRequest : iReadRequest;
  assign owner_active = (state == REQ) || (state == BURST);

  assign iDataIn    = memDataIn;
  assign dDataIn    = memDataIn;
  assign iDataReady = owner_active & ~grantD & memDataReady;
  assign dDataReady = owner_active &  grantD & memDataReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      memReadRequest <= 1'b0;
      memReadAddress <= 32'h0;
      grantD         <= 1'b0;
      count          <= '0;
      errBurst       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iReadRequest || dReadRequest) begin
            state          <= REQ;
            grantD         <= pick_d;
            last_grant     <= pick_d;
            memReadAddress <= pick_d ? dReadAddress : iReadAddress;
            memReadRequest <= 1'b1;
          end
        end
        REQ: begin
          if (memDataReady) begin
            state          <= BURST;
            count          <= CW'(1);
            memReadRequest <= 1'b0;
          end else if (!owner_req) begin
            state          <= IDLE;
            memReadRequest <= 1'b0;
          end
        end
        BURST: begin
          // a burst that ends early is flagged and never wraps the counter
          if (memDataReady) begin
            count <= count + CW'(1);
            if (count == LAST_WORD) state <= TURN;
          end else begin
            state    <= TURN;
            errBurst <= 1'b1;
          end
        end
        TURN: begin
          state <= IDLE;
          count <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
